// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access size codes and FSM states.
package lsu_pkg;

    // Access size codes, funct3 style
    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    // ISSUE drives the memory request, WAIT collects the registered read data
    typedef enum logic {
        ISSUE,
        WAIT
    } lsu_state_t;

endpackage

// File: rtl/lsu_load_extract.sv
// Picks the addressed byte/halfword out of a 32-bit memory word and extends it.
// Purely combinational so the fetch path can share it.
module lsu_load_extract
    import lsu_pkg::*;
(
    input  logic [1:0]  offset_i,
    input  logic [2:0]  size_i,
    input  logic [31:0] data_i,
    output logic [31:0] result_o
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    // Lane selection followed by sign or zero extension according to the size code
    always_comb begin
        byteSel  = data_i[{offset_i, 3'b000} +: 8];
        halfSel  = data_i[{offset_i[1], 4'b0000} +: 16];
        result_o = data_i;
        case (size_i)
            LDST_B:  result_o = {{24{byteSel[7]}}, byteSel};
            LDST_BU: result_o = {24'h000000, byteSel};
            LDST_H:  result_o = {{16{halfSel[15]}}, halfSel};
            LDST_HU: result_o = {16'h0000, halfSel};
            default: result_o = data_i;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: turns core requests into word-wide memory accesses with byte
// enables, stalls the core for the synchronous read, and returns extended loads.
module riscv_lsu
    import lsu_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        lsu_misalign_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    lsu_state_t  state_q, state_d;
    logic [1:0]  offset_q, offset_d;
    logic [2:0]  size_q, size_d;
    logic        load_q, load_d;

    logic        sizeLegal;
    logic        aligned;
    logic        legalReq;
    logic        rdEnable;
    logic [31:0] loadData;

    // Request legality: known size code and natural alignment for that size
    always_comb begin
        sizeLegal = 1'b0;
        aligned   = 1'b0;
        case (core_size_i)
            LDST_B, LDST_BU: begin
                sizeLegal = 1'b1;
                aligned   = 1'b1;
            end
            LDST_H, LDST_HU: begin
                sizeLegal = 1'b1;
                aligned   = ~core_addr_i[0];
            end
            LDST_W: begin
                sizeLegal = 1'b1;
                aligned   = (core_addr_i[1:0] == 2'b00);
            end
            default: begin
                sizeLegal = 1'b0;
                aligned   = 1'b0;
            end
        endcase
        legalReq = core_req_i & sizeLegal & aligned;
    end

    // State and capture registers; offset/size/direction are latched on the accepted edge
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ISSUE;
            offset_q <= 2'b00;
            size_q   <= 3'b000;
            load_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            offset_q <= offset_d;
            size_q   <= size_d;
            load_q   <= load_d;
        end
    end

    // Next state and handshake outputs; reset masks everything visible to core and memory
    always_comb begin
        state_d        = state_q;
        offset_d       = offset_q;
        size_d         = size_q;
        load_d         = load_q;
        mem_req_o      = 1'b0;
        core_stall_o   = 1'b0;
        lsu_misalign_o = 1'b0;
        rdEnable       = 1'b0;
        case (state_q)
            ISSUE: begin
                if (legalReq) begin
                    mem_req_o    = 1'b1;
                    core_stall_o = 1'b1;
                    if (mem_ready_i) begin
                        state_d  = WAIT;
                        offset_d = core_addr_i[1:0];
                        size_d   = core_size_i;
                        load_d   = ~core_we_i;
                    end
                end else if (core_req_i) begin
                    lsu_misalign_o = 1'b1;
                end
            end
            WAIT: begin
                state_d  = ISSUE;
                rdEnable = load_q;
            end
            default: state_d = ISSUE;
        endcase
        if (rst_i) begin
            mem_req_o      = 1'b0;
            core_stall_o   = 1'b0;
            lsu_misalign_o = 1'b0;
            rdEnable       = 1'b0;
        end
    end

    // Byte enables follow the access size and only exist alongside a request
    always_comb begin
        mem_be_o = 4'b0000;
        if (mem_req_o) begin
            case (core_size_i)
                LDST_B, LDST_BU: mem_be_o = 4'b0001 << core_addr_i[1:0];
                LDST_H, LDST_HU: mem_be_o = 4'b0011 << {core_addr_i[1], 1'b0};
                default:         mem_be_o = 4'b1111;
            endcase
        end
    end

    // Store data is replicated across lanes so the byte enables alone pick the target
    always_comb begin
        case (core_size_i)
            LDST_B, LDST_BU: mem_wd_o = {4{core_wd_i[7:0]}};
            LDST_H, LDST_HU: mem_wd_o = {2{core_wd_i[15:0]}};
            default:         mem_wd_o = core_wd_i;
        endcase
    end

    assign mem_we_o   = mem_req_o & core_we_i;
    assign mem_addr_o = core_addr_i;

    lsu_load_extract u_extract (
        .offset_i (offset_q),
        .size_i   (size_q),
        .data_i   (mem_rd_i),
        .result_o (loadData)
    );

    // Load result is only visible in the WAIT cycle of a load
    always_comb begin
        core_rd_o = 32'h0000_0000;
        if (rdEnable) begin
            core_rd_o = loadData;
        end
    end

endmodule
